page_image_scaled: RTL and testbench
====================================

Name: page_image_scaled

Overview:
Parametrised page renderer for the VGA output path. It maps the current scan position onto an image stored in external block memory, with a configurable placement offset, size and power-of-two pixel replication. It fills pixels outside the image with a background colour. A frame-synchronous fade engine brightens or dims the whole page, so page switches in the menu system can fade in and out.

Parameters:
IMG_W, 640, image width in source pixels
IMG_H, 480, image height in source pixels
X0, 0, screen x of image top-left corner
Y0, 0, screen y of image top-left corner
SCALE_SHIFT, 0, replication factor = 2**SCALE_SHIFT in both axes (0..3)
MEM_LAT, 1, read latency of attached memory in cycles (1..3)
ADDR_W, 19, memory address width
BASE_ADDR, 0, word offset of image in memory
BG_COLOR, 12'h000, colour outside image region
FADE_FRAMES, 4, frames per fade level step (>=1)

Ports:
vga_clk  in  1  pixel clock; everything is on the rising edge
vga_rst  in  1  synchronous reset, active-high
x_pos  in  10  current scan column
y_pos  in  10  current scan row
mem_addr  out  ADDR_W  registered read address to image memory
mem_data  in  12  pixel word returned MEM_LAT cycles after mem_addr changes
fade_start  in  1  one-cycle request to begin a fade
fade_dir  in  1  1 = fade in (towards full brightness), 0 = fade out (towards black)
fade_busy  out  1  high while a fade is in progress
fade_done  out  1  one-cycle pulse when a fade reaches its endpoint
pixel_data  out  12  registered output colour: channels [11:8], [7:4], [3:0]

Behaviour:
- Reset (synchronous, vga_rst high at a rising edge) sets:
  - mem_addr=0, pixel_data=0, fade_busy=0, fade_done=0.
  - Fade level=16, state IDLE.
  - Pipeline region flags cleared.
  - Frame-tick history cleared.
- Region test on (x_pos, y_pos) at cycle t:
  - The position is in_region iff X0 <= x < X0+(IMG_W<<SCALE_SHIFT) and Y0 <= y < Y0+(IMG_H<<SCALE_SHIFT).
  - All comparisons are unsigned and widened so they cannot overflow.
- Address:
  - At edge t+1, mem_addr = BASE_ADDR + ((y-Y0)>>SCALE_SHIFT)*IMG_W + ((x-X0)>>SCALE_SHIFT), truncated to ADDR_W.
  - When the position is outside the region, mem_addr = BASE_ADDR.
  - A registered multiplier is permitted.
- Pipeline:
  - The in_region flag travels through a delay line matched to the memory path.
  - At edge t+2+MEM_LAT, pixel_data = fade(in_region ? mem_data : BG_COLOR).
  - Total latency from x/y to pixel_data is MEM_LAT+2 cycles, fixed and independent of region.
- Fade arithmetic:
  - level is 5 bits, range 0..16.
  - Each 4-bit channel c becomes (c*level)>>4.
  - level=16 passes the colour unchanged; level=0 gives black.
  - The level is sampled at the same pipeline stage for every pixel, so there is no mid-pixel tearing.
- Frame tick:
  - One-cycle internal pulse when (x_pos,y_pos)==(0,0) and the previous cycle's position was not (0,0).
- Fade FSM, states IDLE, FADE_IN, FADE_OUT:
  - IDLE + fade_start: go to FADE_IN if fade_dir=1, else FADE_OUT. Clear the frame counter. fade_busy=1 from the next cycle.
  - If the level already equals the target (16 for in, 0 for out), stay IDLE and pulse fade_done on the next cycle.
  - In FADE_IN/FADE_OUT, each frame tick increments a frame counter.
  - When the counter reaches FADE_FRAMES, the counter returns to 0 and level moves 1 towards the target.
  - On reaching the target: go to IDLE, fade_busy=0, fade_done pulses in the same cycle as the final level update.
  - fade_start while busy re-targets immediately from the current level. The counter is cleared and fade_done does not pulse.
  - fade_start coinciding with a step edge: the restart wins and the level does not change that cycle.
- Reset mid-fade: the level returns to 16, the state to IDLE, and no fade_done is issued.
- mem_data is ignored for pixels outside the region.

Test Plan:
- Defaults, MEM_LAT=1. Drive x=5, y=2 at cycle t -> mem_addr=1285 at t+1. With mem_data=12'hABC returned, pixel_data=12'hABC at t+3.
- IMG_W=160, IMG_H=120, SCALE_SHIFT=2, X0=80, Y0=0, BG_COLOR=12'h00F:
  - x=87, y=9 -> mem_addr=321.
  - x=79 -> pixel_data=12'h00F and mem_addr=0, MEM_LAT+2 cycles later.
  - x=719 is inside; x=720 gives BG_COLOR.
- FADE_FRAMES=1, mem_data=12'hFFF, pulse fade_start with fade_dir=0:
  - After 8 frame ticks, level=8 and pixel_data=12'h777.
  - After 16 ticks, pixel_data=0, with a single fade_done pulse and fade_busy falling.
- Fade out for 5 ticks (level 11), then fade_start with fade_dir=1 -> level climbs 12..16 over 5 ticks and fade_done pulses once.
- fade_start with fade_dir=1 at level 16 -> fade_busy stays 0 and fade_done pulses the next cycle.
- Assert vga_rst mid-fade at level 6 -> next cycle level=16, fade_busy=0, pixel_data=0. The output resumes unfaded MEM_LAT+2 cycles after reset is released.

Source files
------------

// File: rtl/page_image_scaled.sv
// page_image_scaled: scaled image page renderer with background fill and frame-synchronous fade
module page_image_scaled #(
  parameter int          IMG_W       = 640,
  parameter int          IMG_H       = 480,
  parameter int          X0          = 0,
  parameter int          Y0          = 0,
  parameter int          SCALE_SHIFT = 0,
  parameter int          MEM_LAT     = 1,
  parameter int          ADDR_W      = 19,
  parameter int          BASE_ADDR   = 0,
  parameter logic [11:0] BG_COLOR    = 12'h000,
  parameter int          FADE_FRAMES = 4
) (
  input  logic              vga_clk,
  input  logic              vga_rst,
  input  logic [9:0]        x_pos,
  input  logic [9:0]        y_pos,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [11:0]       mem_data,
  input  logic              fade_start,
  input  logic              fade_dir,
  output logic              fade_busy,
  output logic              fade_done,
  output logic [11:0]       pixel_data
);
  typedef enum logic [1:0] {S_IDLE, S_IN, S_OUT} state_t;
  localparam logic [32:0] W_SPAN = 33'(IMG_W) << SCALE_SHIFT;
  localparam logic [32:0] H_SPAN = 33'(IMG_H) << SCALE_SHIFT;
  logic [32:0]       dx, dy;
  logic              in_region, zero_pos, tick;
  logic [ADDR_W-1:0] mem_addr_d, mem_addr_q;
  logic [MEM_LAT:0]  reg_q;
  logic [11:0]       src, pixel_d, pixel_q;
  logic              prev_zero_q;
  state_t            state_q;
  logic [4:0]        level_q, tgt, run_tgt, next_lvl;
  logic [15:0]       cnt_q;
  logic              done_q;

  function automatic logic [3:0] scl(input logic [3:0] c, input logic [4:0] l);
    return 4'((9'(c) * 9'(l)) >> 4);
  endfunction

  // A position left of / above the origin wraps to a huge value, so one compare covers both bounds
  assign dx         = 33'(x_pos) - 33'(X0);
  assign dy         = 33'(y_pos) - 33'(Y0);
  assign in_region  = (dx < W_SPAN) && (dy < H_SPAN);
  assign mem_addr_d = in_region ? ADDR_W'(32'(BASE_ADDR) + (dy[31:0] >> SCALE_SHIFT) * 32'(IMG_W) + (dx[31:0] >> SCALE_SHIFT))
                                : ADDR_W'(BASE_ADDR);
  assign zero_pos   = (x_pos == 10'd0) && (y_pos == 10'd0);
  assign tick       = zero_pos && !prev_zero_q;
  assign src        = reg_q[MEM_LAT] ? mem_data : BG_COLOR;
  assign pixel_d    = {scl(src[11:8], level_q), scl(src[7:4], level_q), scl(src[3:0], level_q)};
  assign tgt        = fade_dir ? 5'd16 : 5'd0;
  assign run_tgt    = (state_q == S_IN) ? 5'd16 : 5'd0;
  assign next_lvl   = (state_q == S_IN) ? level_q + 5'd1 : level_q - 5'd1;
  assign mem_addr   = mem_addr_q;
  assign pixel_data = pixel_q;
  assign fade_busy  = state_q != S_IDLE;
  assign fade_done  = done_q;

  // Address/region pipeline: region flag delayed to line up with the returning memory word
  always_ff @(posedge vga_clk) begin
    if (vga_rst) begin
      mem_addr_q  <= '0;
      reg_q       <= '0;
      pixel_q     <= '0;
      prev_zero_q <= 1'b0;
    end else begin
      mem_addr_q  <= mem_addr_d;
      reg_q       <= {reg_q[MEM_LAT-1:0], in_region};
      pixel_q     <= pixel_d;
      prev_zero_q <= zero_pos;
    end
  end

  // Fade engine: a restart always beats a coincident frame step
  always_ff @(posedge vga_clk) begin
    if (vga_rst) begin
      state_q <= S_IDLE;
      level_q <= 5'd16;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (fade_start) begin
        cnt_q   <= '0;
        state_q <= (level_q == tgt) ? S_IDLE : (fade_dir ? S_IN : S_OUT);
        done_q  <= level_q == tgt;
      end else if (state_q != S_IDLE && tick) begin
        cnt_q <= (cnt_q == 16'(FADE_FRAMES - 1)) ? '0 : cnt_q + 16'd1;
        if (cnt_q == 16'(FADE_FRAMES - 1)) begin
          level_q <= next_lvl;
          state_q <= (next_lvl == run_tgt) ? S_IDLE : state_q;
          done_q  <= next_lvl == run_tgt;
        end
      end
    end
  end
endmodule

// File: tb/tb_page_image_scaled.sv
// tb_page_image_scaled: random and directed checks of two renderer configurations against a reference model
module tb_page_image_scaled;
  localparam int LA = 1, LB = 2, FF = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [9:0] x = '0, y = '0;
  logic fs = 1'b0, fd = 1'b0;
  logic [18:0] addr_a, addr_b;
  logic [11:0] md_a, md_b, pix_a, pix_b, ma1, mb1, mb2;
  logic busy_a, done_a, busy_b, done_b;
  int nchk = 0, nfail = 0, ndone = 0, exp_ndone = 0;
  int hx[$], hy[$];
  bit chkp = 1'b1;
  int lvl = 16, tgt = 16, ticks = 0;
  bit active = 1'b0;

  always #5 clk = ~clk;

  page_image_scaled #(.MEM_LAT(LA), .FADE_FRAMES(FF)) dut_a (
    .vga_clk(clk), .vga_rst(rst), .x_pos(x), .y_pos(y), .mem_addr(addr_a), .mem_data(md_a),
    .fade_start(fs), .fade_dir(fd), .fade_busy(busy_a), .fade_done(done_a), .pixel_data(pix_a));

  page_image_scaled #(.IMG_W(160), .IMG_H(120), .X0(80), .Y0(0), .SCALE_SHIFT(2), .MEM_LAT(LB),
                      .BASE_ADDR(7), .BG_COLOR(12'h00F), .FADE_FRAMES(1)) dut_b (
    .vga_clk(clk), .vga_rst(rst), .x_pos(x), .y_pos(y), .mem_addr(addr_b), .mem_data(md_b),
    .fade_start(1'b0), .fade_dir(1'b0), .fade_busy(busy_b), .fade_done(done_b), .pixel_data(pix_b));

  function automatic logic [11:0] mem_f(int a);
    if (a == 0) return 12'hFFF;
    if (a == 1285) return 12'hABC;
    return 12'((a * 37 + 291) % 4096);
  endfunction

  function automatic bit inr(int px, int py, int x0, int y0, int w, int h, int s);
    return px >= x0 && px < x0 + w * s && py >= y0 && py < y0 + h * s;
  endfunction

  function automatic int addr_f(int px, int py, int x0, int y0, int w, int h, int s, int base);
    return (inr(px, py, x0, y0, w, h, s) ? base + ((py - y0) / s) * w + (px - x0) / s : base) % 524288;
  endfunction

  function automatic logic [11:0] fade_f(logic [11:0] c, int l);
    int r, g, b;
    r = c[11:8]; g = c[7:4]; b = c[3:0];
    return {4'(r * l / 16), 4'(g * l / 16), 4'(b * l / 16)};
  endfunction

  function automatic logic [11:0] exp_a(int px, int py);
    return inr(px, py, 0, 0, 640, 480, 1) ? mem_f(addr_f(px, py, 0, 0, 640, 480, 1, 0)) : 12'h000;
  endfunction

  function automatic logic [11:0] exp_b(int px, int py);
    return inr(px, py, 80, 0, 160, 120, 4) ? mem_f(addr_f(px, py, 80, 0, 160, 120, 4, 7)) : 12'h00F;
  endfunction

  // memory models: A returns a word one cycle after the address, B two cycles
  always @(posedge clk) begin
    ma1 <= mem_f(int'(addr_a));
    mb1 <= mem_f(int'(addr_b));
    mb2 <= mb1;
  end
  assign md_a = ma1;
  assign md_b = mb2;

  always @(negedge clk) if (done_a === 1'b1) ndone++;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
    nchk++;
    assert (obs === expv) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic drive(int xx, int yy);
    int n;
    x = 10'(xx); y = 10'(yy);
    @(posedge clk); #1;
    if (rst) begin
      hx.delete(); hy.delete();
      return;
    end
    hx.push_back(xx); hy.push_back(yy);
    n = hx.size();
    chk("addr_a", 32'(addr_a), 32'(addr_f(xx, yy, 0, 0, 640, 480, 1, 0)));
    chk("addr_b", 32'(addr_b), 32'(addr_f(xx, yy, 80, 0, 160, 120, 4, 7)));
    if (n >= LA + 2 && chkp) chk("pix_a", 32'(pix_a), 32'(fade_f(exp_a(hx[n-LA-2], hy[n-LA-2]), lvl)));
    if (n >= LB + 2) chk("pix_b", 32'(pix_b), 32'(exp_b(hx[n-LB-2], hy[n-LB-2])));
  endtask

  task automatic settle();
    repeat (LA + 2) drive(0, 0);
    chkp = 1'b1;
    drive(0, 0);
  endtask

  task automatic tick();
    bit ed;
    chkp = 1'b0;
    drive(1, 0);
    drive(0, 0);
    ed = 1'b0;
    if (active) begin
      ticks++;
      if (ticks % FF == 0) begin
        lvl += (tgt > lvl) ? 1 : -1;
        if (lvl == tgt) begin active = 1'b0; ed = 1'b1; exp_ndone++; end
      end
    end
    chk("tick_done", 32'(done_a), 32'(ed));
    chk("tick_busy", 32'(busy_a), 32'(active));
    settle();
  endtask

  task automatic start(bit d, bit with_tick);
    bit ed;
    chkp = 1'b0;
    if (with_tick) drive(1, 0);
    fs = 1'b1; fd = d;
    drive(0, 0);
    fs = 1'b0;
    tgt = d ? 16 : 0;
    ticks = 0;
    ed = (lvl == tgt);
    active = !ed;
    if (ed) exp_ndone++;
    chk("start_done", 32'(done_a), 32'(ed));
    chk("start_busy", 32'(busy_a), 32'(active));
    settle();
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0);
    drive(0, 0);
    chk("rst_addr_a", 32'(addr_a), 0);
    chk("rst_addr_b", 32'(addr_b), 0);
    chk("rst_pix_a", 32'(pix_a), 0);
    chk("rst_pix_b", 32'(pix_b), 0);
    chk("rst_busy", 32'(busy_a), 0);
    chk("rst_done", 32'(done_a), 0);
    rst = 1'b0;
    drive(5, 2);
    chk("plan_addr", 32'(addr_a), 1285);
    drive(5, 2);
    drive(5, 2);
    chk("plan_abc", 32'(pix_a), 32'h0ABC);
    drive(87, 9);
    chk("plan_addr_b", 32'(addr_b), 328);
    foreach (hx[i]) ;
    drive(719, 5); drive(720, 5); drive(79, 5); drive(80, 5); drive(639, 479);
    drive(640, 479); drive(639, 480); drive(0, 479); drive(1023, 1023); drive(719, 479);
    drive(720, 480); drive(80, 479);
    repeat (300) begin
      if ($urandom_range(0, 3) == 0) drive(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)));
      else drive(int'($urandom_range(0, 799)), int'($urandom_range(0, 524)));
    end
    drive(0, 0);
    start(1'b0, 1'b0);
    repeat (10) tick();
    start(1'b1, 1'b0);
    repeat (10) tick();
    chk("fade_in_full", 32'(pix_a), 32'h0FFF);
    start(1'b1, 1'b0);
    start(1'b0, 1'b0);
    repeat (16) tick();
    chk("half_level", 32'(pix_a), 32'h0777);
    repeat (16) tick();
    chk("black", 32'(pix_a), 0);
    start(1'b1, 1'b0);
    tick();
    start(1'b1, 1'b1);
    repeat (20) tick();
    chk("restart_lvl", 32'(pix_a), 32'(fade_f(12'hFFF, 10)));
    start(1'b0, 1'b0);
    repeat (8) tick();
    chk("lvl6", 32'(pix_a), 32'(fade_f(12'hFFF, 6)));
    rst = 1'b1;
    drive(0, 0);
    chk("midrst_busy", 32'(busy_a), 0);
    chk("midrst_done", 32'(done_a), 0);
    chk("midrst_pix", 32'(pix_a), 0);
    rst = 1'b0;
    lvl = 16; active = 1'b0; tgt = 16;
    repeat (40) drive(int'($urandom_range(0, 799)), int'($urandom_range(0, 524)));
    drive(0, 0);
    @(negedge clk);
    chk("done_count", 32'(ndone), 32'(exp_ndone));
    chk("busy_b", 32'(busy_b), 0);
    chk("done_b", 32'(done_b), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nchk, nfail);
    $finish;
  end
endmodule
